// File: rtl/predecode_bundle.sv
// rtl/predecode_bundle.sv - fetch-bundle control-flow predecoder with 2-entry output FIFO; optional PREDECODE_PERF_EN counters
module predecode_bundle #(
  parameter int N_LANES = 4,
  parameter int PD_W    = 4,
  localparam int IDX_W  = (N_LANES > 1) ? $clog2(N_LANES) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [63:0]             in_pc,
  input  logic [32*N_LANES-1:0]   in_insns,
  input  logic [N_LANES-1:0]      in_lane_mask,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [63:0]             out_pc,
  output logic [32*N_LANES-1:0]   out_insns,
  output logic [PD_W*N_LANES-1:0] out_pd,
  output logic [N_LANES-1:0]      out_cflow_mask,
  output logic                    out_has_cflow,
  output logic [IDX_W-1:0]        out_first_idx,
  output logic [63:0]             out_first_target
`ifdef PREDECODE_PERF_EN
  ,
  output logic [63:0]             perf_bundles,
  output logic [63:0]             perf_cflows
`endif
);

  localparam logic [2:0] PD_NONE = 3'd0;
  localparam logic [2:0] PD_BR   = 3'd1;
  localparam logic [2:0] PD_RET  = 3'd2;
  localparam logic [2:0] PD_J    = 3'd3;
  localparam logic [2:0] PD_JR   = 3'd4;
  localparam logic [2:0] PD_JAL  = 3'd5;
  localparam logic [2:0] PD_CALL = 3'd6;
  localparam logic [2:0] PD_CORO = 3'd7;

  // x1 (ra) and x5 (t0) are the RISC-V link registers for return-address prediction hints.
  function automatic logic is_link(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

  function automatic logic [2:0] classify(input logic [6:0] opcode, input logic [4:0] rd,
                                          input logic [4:0] rs1);
    logic [2:0] c;
    c = PD_NONE;
    case (opcode)
      7'h63: c = PD_BR;
      7'h6F: c = is_link(rd) ? PD_JAL : PD_J;
      7'h67: begin
        if (rd == 5'd0)                   c = is_link(rs1) ? PD_RET : PD_JR;
        else if (is_link(rd) && is_link(rs1)) c = (rd == rs1) ? PD_CALL : PD_CORO;
        else if (is_link(rd))             c = PD_CALL;
        else                              c = PD_JR;
      end
      default: c = PD_NONE;
    endcase
    return c;
  endfunction

  logic [2:0]              lane_code [N_LANES];
  logic [PD_W*N_LANES-1:0] dec_pd;
  logic [N_LANES-1:0]      dec_cmask;
  logic [IDX_W-1:0]        dec_idx;
  logic [2:0]              sel_code;
  logic [24:0]             sel_hi;
  logic [63:0]             lane_pc;
  logic [63:0]             b_imm;
  logic [63:0]             j_imm;
  logic [63:0]             dec_target;

  // Per-lane classification; masked-off lanes are forced to "none".
  always_comb begin
    dec_pd    = '0;
    dec_cmask = '0;
    for (int i = 0; i < N_LANES; i++) begin
      lane_code[i] = PD_NONE;
      if (in_lane_mask[i])
        lane_code[i] = classify(in_insns[32*i +: 7], in_insns[32*i+7 +: 5], in_insns[32*i+15 +: 5]);
      dec_pd[PD_W*i +: PD_W] = PD_W'(lane_code[i]);
      dec_cmask[i]           = (lane_code[i] != PD_NONE);
    end
  end

  // Lowest control-flow lane; scanning downward lets the lowest hit win. Zero when none.
  always_comb begin
    dec_idx = '0;
    for (int i = N_LANES - 1; i >= 0; i--) begin
      if (dec_cmask[i]) dec_idx = IDX_W'(i);
    end
  end

  // Static target of the first control-flow lane. sel_hi holds insn bits [31:7] of that lane.
  always_comb begin
    sel_code = lane_code[dec_idx];
    sel_hi   = in_insns[32*dec_idx + 7 +: 25];
    lane_pc  = in_pc + {{(62-IDX_W){1'b0}}, dec_idx, 2'b00};
    b_imm    = {{51{sel_hi[24]}}, sel_hi[24], sel_hi[0], sel_hi[23:18], sel_hi[4:1], 1'b0};
    j_imm    = {{43{sel_hi[24]}}, sel_hi[24], sel_hi[12:5], sel_hi[13], sel_hi[23:14], 1'b0};
    if (sel_code == PD_BR)                         dec_target = lane_pc + b_imm;
    else if (sel_code == PD_J || sel_code == PD_JAL) dec_target = lane_pc + j_imm;
    else                                           dec_target = '0;
  end

  logic [1:0] count;
  logic       wr_ptr;
  logic       rd_ptr;
  logic       push;
  logic       pop;

  logic [63:0]             st_pc     [2];
  logic [32*N_LANES-1:0]   st_insns  [2];
  logic [PD_W*N_LANES-1:0] st_pd     [2];
  logic [N_LANES-1:0]      st_cmask  [2];
  logic [IDX_W-1:0]        st_idx    [2];
  logic [63:0]             st_target [2];

  assign in_ready  = ~count[1];
  assign out_valid = (count != 2'd0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  // Payload slots are written only on accept and need no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      st_pc[wr_ptr]     <= in_pc;
      st_insns[wr_ptr]  <= in_insns;
      st_pd[wr_ptr]     <= dec_pd;
      st_cmask[wr_ptr]  <= dec_cmask;
      st_idx[wr_ptr]    <= dec_idx;
      st_target[wr_ptr] <= dec_target;
    end
  end

  // Occupancy and pointers; flush wins over any same-cycle accept or pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else if (flush) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // Head entry drives the outputs; everything reads as zero while empty.
  always_comb begin
    out_pc           = '0;
    out_insns        = '0;
    out_pd           = '0;
    out_cflow_mask   = '0;
    out_has_cflow    = 1'b0;
    out_first_idx    = '0;
    out_first_target = '0;
    if (out_valid) begin
      out_pc           = st_pc[rd_ptr];
      out_insns        = st_insns[rd_ptr];
      out_pd           = st_pd[rd_ptr];
      out_cflow_mask   = st_cmask[rd_ptr];
      out_has_cflow    = |st_cmask[rd_ptr];
      out_first_idx    = st_idx[rd_ptr];
      out_first_target = st_target[rd_ptr];
    end
  end

`ifdef PREDECODE_PERF_EN
  // Pop-driven statistics; only reset clears them, flush leaves them alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_bundles <= '0;
      perf_cflows  <= '0;
    end else if (pop) begin
      perf_bundles <= perf_bundles + 64'd1;
      perf_cflows  <= perf_cflows + 64'($countones(out_cflow_mask));
    end
  end
`endif

endmodule

// File: tb/tb_predecode_bundle.sv
// tb/tb_predecode_bundle.sv - randomized model-checked bench for predecode_bundle
module tb_predecode_bundle;
  localparam int NL = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] JAL = 32'h0080_00EF;
  localparam logic [31:0] RET = 32'h0000_8067;
  localparam logic [31:0] BEQ = 32'h0000_0063;
  localparam logic [31:0] J8  = 32'h0080_006F;

  logic          clk = 1'b0;
  logic          reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [63:0]   in_pc, out_pc, out_first_target;
  logic [127:0]  in_insns, out_insns;
  logic [3:0]    in_lane_mask, out_cflow_mask;
  logic [15:0]   out_pd;
  logic          out_has_cflow;
  logic [1:0]    out_first_idx;
`ifdef PREDECODE_PERF_EN
  logic [63:0]   perf_bundles, perf_cflows;
`endif

  predecode_bundle dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_insns(in_insns),
    .in_lane_mask(in_lane_mask), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_insns(out_insns), .out_pd(out_pd), .out_cflow_mask(out_cflow_mask),
    .out_has_cflow(out_has_cflow), .out_first_idx(out_first_idx), .out_first_target(out_first_target)
`ifdef PREDECODE_PERF_EN
    , .perf_bundles(perf_bundles), .perf_cflows(perf_cflows)
`endif
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic [63:0]  pc;
    logic [127:0] insns;
    logic [15:0]  pd;
    logic [3:0]   cm;
    logic         has;
    logic [1:0]   idx;
    logic [63:0]  tgt;
  } exp_t;

  exp_t q[$];
  longint unsigned m_bundles, m_cflows;

  function automatic int ref_code(logic [31:0] w);
    int op, rd, rs;
    bit rdl, rsl;
    op = int'(w[6:0]); rd = int'(w[11:7]); rs = int'(w[19:15]);
    rdl = (rd == 1 || rd == 5);
    rsl = (rs == 1 || rs == 5);
    if (op == 'h63) return 1;
    if (op == 'h6F) return rdl ? 5 : 3;
    if (op == 'h67) begin
      if (rd == 0) return rsl ? 2 : 4;
      if (rdl && rsl) return (rd == rs) ? 6 : 7;
      if (rdl) return 6;
      return 4;
    end
    return 0;
  endfunction

  function automatic longint bimm(logic [31:0] w);
    longint v;
    v = longint'(w[11:8]) * 2 + longint'(w[30:25]) * 32 + longint'(w[7]) * 2048;
    if (w[31]) v = v - 4096;
    return v;
  endfunction

  function automatic longint jimm(logic [31:0] w);
    longint v;
    v = longint'(w[30:21]) * 2 + longint'(w[20]) * 2048 + longint'(w[19:12]) * 4096;
    if (w[31]) v = v - (longint'(1) << 20);
    return v;
  endfunction

  function automatic exp_t build(logic [63:0] pc, logic [127:0] ins, logic [3:0] mask);
    exp_t e;
    int codes[NL];
    bit found;
    logic [31:0] w;
    logic [63:0] lpc;
    e.pc = pc; e.insns = ins; e.pd = '0; e.cm = '0; e.has = 0; e.idx = 0; e.tgt = 0;
    found = 0;
    for (int i = 0; i < NL; i++) begin
      w = ins[32*i +: 32];
      codes[i] = mask[i] ? ref_code(w) : 0;
      e.pd[4*i +: 4] = 4'(codes[i]);
      e.cm[i] = (codes[i] != 0);
      if (codes[i] != 0 && !found) begin
        found = 1;
        e.idx = 2'(i);
        lpc = pc + 64'(4 * i);
        if (codes[i] == 1) e.tgt = lpc + 64'(bimm(w));
        else if (codes[i] == 3 || codes[i] == 5) e.tgt = lpc + 64'(jimm(w));
      end
    end
    e.has = found;
    return e;
  endfunction

  // Reference FIFO: follows the handshake rules directly on a queue.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
      m_bundles = 0;
      m_cflows  = 0;
    end else begin
      bit acc, pp;
      acc = in_valid && (q.size() < 2) && !flush;
      pp  = (q.size() > 0) && out_ready && !flush;
      if (flush) q.delete();
      else begin
        if (pp) begin
          m_bundles = m_bundles + 1;
          m_cflows  = m_cflows + longint'($countones(q[0].cm));
          void'(q.pop_front());
        end
        if (acc) q.push_back(build(in_pc, in_insns, in_lane_mask));
      end
    end
  end

  // Compare process: every falling edge, DUT against the reference queue.
  always @(negedge clk) begin
    chk("out_valid", out_valid, q.size() != 0);
    chk("in_ready", in_ready, q.size() < 2);
    if (q.size() != 0) begin
      chk("out_pc", out_pc, q[0].pc);
      chk("out_insns", out_insns, q[0].insns);
      chk("out_pd", out_pd, q[0].pd);
      chk("out_cflow_mask", out_cflow_mask, q[0].cm);
      chk("out_has_cflow", out_has_cflow, q[0].has);
      chk("out_first_idx", out_first_idx, q[0].idx);
      chk("out_first_target", out_first_target, q[0].tgt);
    end else begin
      chk("idle_zero_a", {out_pc, out_insns}, '0);
      chk("idle_zero_b", {out_pd, out_cflow_mask, out_has_cflow, out_first_idx, out_first_target}, '0);
    end
`ifdef PREDECODE_PERF_EN
    chk("perf_bundles", perf_bundles, m_bundles);
    chk("perf_cflows", perf_cflows, m_cflows);
`endif
  end

  function automatic logic [4:0] pick_reg();
    case ($urandom_range(0, 3))
      0: return 5'd0;
      1: return 5'd1;
      2: return 5'd5;
      default: return 5'($urandom);
    endcase
  endfunction

  function automatic logic [31:0] rand_insn();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 5))
      0: w[6:0] = 7'h63;
      1: w[6:0] = 7'h6F;
      2, 3: w[6:0] = 7'h67;
      default: ;
    endcase
    w[11:7]  = pick_reg();
    w[19:15] = pick_reg();
    return w;
  endfunction

  task automatic offer(input logic [63:0] pc, input logic [127:0] ins, input logic [3:0] mask);
    in_valid = 1'b1; in_pc = pc; in_insns = ins; in_lane_mask = mask;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_insns = '0; in_lane_mask = '0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("post_rst_out_valid", out_valid, 1'b0);
    chk("post_rst_in_ready", in_ready, 1'b1);

    // jal x1,+8 in lane 2
    #1 offer(64'h1000, {NOP, JAL, NOP, NOP}, 4'hF);
    @(negedge clk);
    chk("jal_valid", out_valid, 1'b1);
    chk("jal_pd2", out_pd[11:8], 4'd5);
    chk("jal_mask", out_cflow_mask, 4'b0100);
    chk("jal_idx", out_first_idx, 2'd2);
    chk("jal_target", out_first_target, 64'h1010);
    #1 in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);

    // ret in lane 0, beq in lane 1
    #1 offer(64'h5000, {NOP, NOP, BEQ, RET}, 4'hF);
    @(negedge clk);
    chk("ret_pd0", out_pd[3:0], 4'd2);
    chk("ret_pd1", out_pd[7:4], 4'd1);
    chk("ret_idx", out_first_idx, 2'd0);
    chk("ret_target", out_first_target, 64'h0);

    // lane 3 control flow masked off
    #1 offer(64'h6000, {JAL, NOP, NOP, NOP}, 4'b0001);
    @(negedge clk);
    chk("mask_has", out_has_cflow, 1'b0);
    chk("mask_cm", out_cflow_mask, 4'b0000);
    chk("mask_idx", out_first_idx, 2'd0);

    // lane pc wraps past 2^64
    #1 offer(64'hFFFF_FFFF_FFFF_FFF8, {J8, NOP, NOP, NOP}, 4'hF);
    @(negedge clk);
    chk("wrap_pd3", out_pd[15:12], 4'd3);
    chk("wrap_target", out_first_target, 64'hC);
    #1 in_valid = 1'b0;
    @(negedge clk);

    // backpressure: fill, stall, release
    #1 out_ready = 1'b0; offer(64'h2000, {4{NOP}}, 4'hF);
    @(negedge clk);
    #1 offer(64'h3000, {4{BEQ}}, 4'hF);
    @(negedge clk);
    chk("full_in_ready", in_ready, 1'b0);
    chk("stall_head", out_pc, 64'h2000);
    #1 offer(64'h4000, {4{RET}}, 4'hF);
    @(negedge clk);
    chk("stall_hold", out_pc, 64'h2000);
    #1 in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("order_second", out_pc, 64'h3000);
    @(negedge clk);
    chk("drained", out_valid, 1'b0);

    // flush with two held and a bundle on offer
    #1 out_ready = 1'b0; offer(64'h7000, {4{NOP}}, 4'hF);
    @(negedge clk);
    #1 offer(64'h7100, {4{NOP}}, 4'hF);
    @(negedge clk);
    #1 flush = 1'b1; offer(64'h7200, {4{JAL}}, 4'hF);
    @(negedge clk);
    chk("flush_valid", out_valid, 1'b0);
    chk("flush_ready", in_ready, 1'b1);
    #1 flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("flush_dropped", out_valid, 1'b0);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      #1;
      in_valid  = ($urandom_range(0, 99) < 60);
      out_ready = ($urandom_range(0, 99) < 60);
      flush     = ($urandom_range(0, 99) < 4);
      in_pc     = ($urandom_range(0, 9) == 0) ? 64'hFFFF_FFFF_FFFF_FFF4 : {$urandom, $urandom};
      for (int l = 0; l < NL; l++) in_insns[32*l +: 32] = rand_insn();
      in_lane_mask = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
      @(negedge clk);
    end

    // reset while bundles are held
    #1 flush = 1'b0; out_ready = 1'b0; offer(64'h8000, {4{BEQ}}, 4'hF);
    @(negedge clk);
    #1 offer(64'h8100, {4{BEQ}}, 4'hF);
    @(negedge clk);
    #1 in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_valid", out_valid, 1'b0);
    chk("rst_mid_ready", in_ready, 1'b1);
    @(negedge clk);
    #1 reset = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("rst_after_valid", out_valid, 1'b0);

`ifdef PREDECODE_PERF_EN
    // three pops, two control-flow lanes each
    #1 reset = 1'b1;
    @(negedge clk);
    #1 reset = 1'b0; out_ready = 1'b1;
    offer(64'h9000, {NOP, NOP, BEQ, BEQ}, 4'hF);
    repeat (3) @(negedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("perf_b3", perf_bundles, 64'd3);
    chk("perf_c6", perf_cflows, 64'd6);
    #1 reset = 1'b1;
    #1;
    chk("perf_b_rst", perf_bundles, 64'd0);
    chk("perf_c_rst", perf_cflows, 64'd0);
    @(negedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/predecode_bundle.md
PREDECODE_BUNDLE -- requirements
Module: predecode_bundle

Interface
REQ-001 SHALL have parameter N_LANES, default 4: instructions per fetch bundle, power of two, 2..8.
REQ-002 SHALL have parameter PD_W, default 4: width of each per-lane predecode code.
REQ-003 SHALL have port clk, input, 1: sole clock, all state on rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port flush, input, 1: discard all buffered bundles.
REQ-006 SHALL have port in_valid, input, 1: bundle offered.
REQ-007 SHALL have port in_ready, output, 1: bundle can be accepted.
REQ-008 SHALL have port in_pc, input, 64: pc of lane 0.
REQ-009 SHALL have port in_insns, input, 32*N_LANES: lane i at bits [32i+31:32i].
REQ-010 SHALL have port in_lane_mask, input, N_LANES: lane valid bits.
REQ-011 SHALL have ports out_valid (output, 1) and out_ready (input, 1): output handshake.
REQ-012 SHALL have ports out_pc (output, 64) and out_insns (output, 32*N_LANES): bundle passthrough.
REQ-013 SHALL have port out_pd, output, PD_W*N_LANES: per-lane code.
REQ-014 SHALL have port out_cflow_mask, output, N_LANES: lanes with nonzero code.
REQ-015 SHALL have ports out_has_cflow (output, 1) and out_first_idx (output, log2(N_LANES)): lowest cflow lane.
REQ-016 SHALL have port out_first_target, output, 64: static target of lowest cflow lane.

Function
REQ-017 Codes SHALL be: 0 none, 1 cond branch (opcode 63h), 2 return, 3 j, 4 jr, 5 jal, 6 jalr/indirect call, 7 coroutine; link = x1 or x5.
REQ-018 Opcode 6Fh SHALL give 5 if rd is link, else 3.
REQ-019 Opcode 67h with rd=0 SHALL give 2 if rs1 is link, else 4; with rd!=0: both link -> 6 if rd==rs1 else 7; rd link only -> 6; otherwise 4.
REQ-020 Masked-off lanes SHALL produce code 0 and mask bit 0.
REQ-021 Lane i pc SHALL be in_pc + 4*i, mod 2^64.
REQ-022 out_first_target SHALL be lane pc + sign-extended B-imm (code 1) or J-imm (codes 3, 5), mod 2^64; 0 for codes 2, 4, 6, 7 or no cflow.
REQ-023 out_first_idx SHALL be 0 when out_has_cflow is 0.
REQ-024 Decode SHALL be computed at input and stored in a 2-entry FIFO; out_* SHALL present the head entry.
REQ-025 Accept SHALL occur when in_valid and in_ready; in_ready SHALL be 1 iff fewer than 2 entries are held, independent of out_ready.
REQ-026 Latency SHALL be 1 cycle: bundle accepted into empty FIFO is out_valid next cycle.
REQ-027 Pop SHALL occur when out_valid and out_ready; simultaneous accept and pop with 2 entries held is impossible, since in_ready=0; with 1 held, count SHALL remain 1 and order SHALL be preserved.
REQ-028 Output fields SHALL hold stable while out_valid and not out_ready.
REQ-029 flush SHALL empty the FIFO next cycle, override any same-cycle accept or pop, and drop the offered bundle.
REQ-030 Pointers SHALL wrap modulo 2.

Reset
REQ-031 Reset SHALL asynchronously clear count and pointers; out_valid=0, in_ready=1 while asserted and the cycle after deassertion.
REQ-032 Payload storage SHALL need no reset; out_* data SHALL be 0 when out_valid=0.
REQ-033 Reset mid-transfer SHALL drop all held bundles without output.

Configuration
REQ-034 With PREDECODE_PERF_EN defined, SHALL add outputs perf_bundles (64) and perf_cflows (64), reset to 0, incremented on each pop, by 1 and by popcount(out_cflow_mask) respectively, wrapping mod 2^64, unaffected by flush.
REQ-035 Without PREDECODE_PERF_EN, those ports and counters SHALL not exist; all other behaviour is identical.

Verification
REQ-036 N=4, pc=1000h, lane 2 = jal x1,+8 (0080_00EFh), mask Fh -> next cycle pd lane2=5, mask 0100b, idx 2, target 1010h.
REQ-037 Lane 0 = 0000_8067h (ret), lane1 = beq -> idx 0, pd0=2, pd1=1, target 0.
REQ-038 out_ready=0, two accepts -> in_ready 0 on third; release -> bundles exit in order, fields stable while stalled.
REQ-039 Two held, flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, offered bundle never appears.
REQ-040 Mask 0001b, cflow in lane 3 only -> has_cflow=0, mask 0, idx 0.
REQ-041 PREDECODE_PERF_EN, 3 pops of 2 cflows each -> perf_bundles=3, perf_cflows=6; assert reset -> both 0.
